// File: rtl/cmp_pkg.sv
// Shared sizing, FSM state encoding and index types for the compare arbiter.
package cmp_pkg;

  localparam int N_REQ = 4;
  localparam int W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [1:0] req_idx_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } rr_pick_t;

endpackage

// File: rtl/cmp_arbiter_mag.sv
// Unsigned magnitude comparator; exactly one of less/equal/greater is high.
module cmp_arbiter_mag
  import cmp_pkg::*;
#(
  parameter int DATA_W = cmp_pkg::W
) (
  input  logic [DATA_W-1:0] Din_A,
  input  logic [DATA_W-1:0] Din_B,
  output logic              less,
  output logic              equal,
  output logic              greater
);

  always_comb begin
    less    = (Din_A <  Din_B);
    equal   = (Din_A == Din_B);
    greater = (Din_A >  Din_B);
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding one shared comparator; one transaction in flight at a time.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int N_REQ = cmp_pkg::N_REQ,
  parameter int W     = cmp_pkg::W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_bus,
  input  logic [N_REQ*W-1:0] b_bus,
  output logic [N_REQ-1:0]   grant,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic               less,
  output logic               equal,
  output logic               greater,
  output logic               busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  req_idx_t         r_ptr;
  req_idx_t         r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [N_REQ-1:0] r_grant;
  logic             r_rsp_valid;
  req_idx_t         r_rsp_id;
  logic             r_less;
  logic             r_equal;
  logic             r_greater;

  rr_pick_t         w_pick;
  logic [W-1:0]     w_a_sel;
  logic [W-1:0]     w_b_sel;
  logic             w_less;
  logic             w_equal;
  logic             w_greater;

  // Search ptr, ptr+1, ... wrapping; descending scan so the nearest hit wins.
  function automatic rr_pick_t f_rr_pick(input logic [N_REQ-1:0] req_v,
                                         input req_idx_t          ptr);
    rr_pick_t pick;
    req_idx_t j;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = req_idx_t'((int'(ptr) + k) % N_REQ);
      if (req_v[j]) begin
        pick.found = 1'b1;
        pick.idx   = j;
      end
    end
    return pick;
  endfunction

  always_comb begin
    w_pick  = f_rr_pick(req, r_ptr);
    w_a_sel = a_bus[w_pick.idx*W +: W];
    w_b_sel = b_bus[w_pick.idx*W +: W];
  end

  cmp_arbiter_mag #(.DATA_W(W)) u_mag (
    .Din_A   (r_a),
    .Din_B   (r_b),
    .less    (w_less),
    .equal   (w_equal),
    .greater (w_greater)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick.found) w_state_nxt = CMP;
      CMP:     w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_grant     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_less      <= 1'b0;
      r_equal     <= 1'b0;
      r_greater   <= 1'b0;
    end else begin
      r_grant <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick.found) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_idx   <= w_pick.idx;
            r_grant <= N_REQ'(1) << w_pick.idx;
          end
        end
        CMP: begin
          r_less      <= w_less;
          r_equal     <= w_equal;
          r_greater   <= w_greater;
          r_rsp_id    <= r_idx;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= req_idx_t'((int'(r_rsp_id) + 1) % N_REQ);
          end
        end
        default: ;
      endcase
    end
  end

  assign grant     = r_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign less      = r_less;
  assign equal     = r_equal;
  assign greater   = r_greater;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: expected grants/responses queued at stimulus time.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic [3:0]  grant;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic        less, equal, greater, busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] gq[$];
  logic [4:0] rq[$];
  int         m_ptr = 0;
  logic       auto_drop = 1'b1;

  always #5 clk = ~clk;

  cmp_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .less      (less),
    .equal     (equal),
    .greater   (greater),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~grant;
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    a_bus[i*4 +: 4] = a;
    b_bus[i*4 +: 4] = b;
  endtask

  // Reference: serve the mask in round-robin order from the model pointer.
  task automatic submit(input logic [3:0] mask);
    logic [3:0] rem;
    logic [3:0] a, b;
    int         idx;
    rem = mask;
    while (rem != 4'b0) begin
      idx = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (rem[idx]) break;
      end
      a = a_bus[idx*4 +: 4];
      b = b_bus[idx*4 +: 4];
      gq.push_back(4'b0001 << idx);
      rq.push_back({2'(idx), (a < b), (a == b), (a > b)});
      m_ptr    = (idx + 1) % 4;
      rem[idx] = 1'b0;
    end
    req = req | mask;
  endtask

  task automatic wait_drain(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (gq.size() == 0 && rq.size() == 0 && !busy && req == 4'b0) break;
      tick();
    end
    chk("drain_grants", 32'(gq.size()), 32'd0);
    chk("drain_rsps", 32'(rq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [3:0] eg;
    logic [4:0] er;
    if (grant != 4'b0) begin
      if (gq.size() == 0) chk("grant_extra", 32'(grant), 32'd0);
      else begin
        eg = gq.pop_front();
        chk("grant", 32'(grant), 32'(eg));
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rq.size() == 0) chk("rsp_extra", 32'(rsp_valid), 32'd0);
      else begin
        er = rq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(er[4:3]));
        chk("rsp_flags", 32'({less, equal, greater}), 32'(er[2:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_flags", 32'({less, equal, greater}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_ptr = 0;

    // All four request together from ptr=0, A=15 B=11 everywhere.
    for (int i = 0; i < 4; i++) set_ops(i, 4'd15, 4'd11);
    submit(4'b1111);
    wait_drain(40);

    // Single requester 2, checked cycle by cycle for latency.
    set_ops(2, 4'd10, 4'd12);
    submit(4'b0100);
    tick();
    chk("lat_grant", 32'(grant), 32'b0100);
    chk("lat_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_grant_off", 32'(grant), 32'd0);
    chk("lat_valid", 32'(rsp_valid), 32'd1);
    chk("lat_id", 32'(rsp_id), 32'd2);
    chk("lat_less", 32'(less), 32'd1);
    wait_drain(20);

    // Serve id1 so ptr=2, then 1001 must go 3 first, then 0.
    set_ops(1, 4'd4, 4'd4);
    submit(4'b0010);
    wait_drain(20);
    set_ops(3, 4'd10, 4'd10);
    set_ops(0, 4'd3, 4'd9);
    submit(4'b1001);
    wait_drain(30);

    // Backpressure: response held five cycles, a new request waits.
    rsp_ready = 1'b0;
    set_ops(0, 4'd5, 4'd5);
    submit(4'b0001);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_id", 32'(rsp_id), 32'd0);
      chk("hold_flags", 32'({less, equal, greater}), 32'b010);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_grant", 32'(grant), 32'd0);
      if (c == 1) begin
        set_ops(2, 4'd1, 4'd0);
        submit(4'b0100);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_valid", 32'(rsp_valid), 32'd0);
    wait_drain(20);

    // Operands of the granted requester change during CMP.
    set_ops(1, 4'd9, 4'd3);
    submit(4'b0010);
    tick();
    set_ops(1, 4'd1, 4'd14);
    wait_drain(20);

    // Reset during CMP abandons the transaction; held req re-granted after.
    auto_drop = 1'b0;
    set_ops(3, 4'd7, 4'd2);
    gq.push_back(4'b1000);
    req = 4'b1000;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_flags", 32'({less, equal, greater}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    auto_drop = 1'b1;
    submit(4'b1000);
    tick();
    chk("regrant", 32'(grant), 32'b1000);
    wait_drain(20);

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
